// File: rtl/shift_deserializer.sv
// shift_deserializer
// Collects the bits shifted out of the MSB of an upstream 8-bit shift register,
// rebuilds MSB-first words, and presents each word with even parity on a
// valid/ready output. A completed word that finds the output still occupied is
// dropped and raises a sticky overrun flag. SYNC restarts word framing.
module shift_deserializer #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             Clr,
    input  logic             SIN,
    input  logic             SHIFT,
    input  logic             SYNC,
    input  logic             DREADY,
    output logic [WIDTH-1:0] DOUT,
    output logic             DVALID,
    output logic             PAR,
    output logic             OVF,
    output logic [CW-1:0]    COUNT
);

    // Output holding register is either empty or holds an unconsumed word.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t             state_reg;
    // Only the low WIDTH-1 bits of the accumulator are ever needed: the word
    // is formed from them plus SIN on the completing edge, so the top bit
    // would never be read.
    logic [WIDTH-2:0]   acc_reg;
    logic [CW-1:0]      count_reg;
    logic [WIDTH-1:0]   dout_reg;
    logic               par_reg;
    logic               ovf_reg;

    logic [WIDTH-1:0]   word_next;
    logic [WIDTH-1:0]   par_chain;
    logic               last_bit;

    // Candidate word: accumulator shifted left with the incoming bit appended.
    assign word_next = {acc_reg, SIN};
    assign last_bit  = (count_reg == CW'(WIDTH - 1));

    // Even parity of the candidate word as an XOR chain.
    assign par_chain[0] = word_next[0];
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_par
            assign par_chain[gi] = par_chain[gi-1] ^ word_next[gi];
        end
    endgenerate

    // Framing, word completion, output handshake and overrun tracking.
    always_ff @(posedge CLK) begin
        if (!Clr) begin
            state_reg <= ST_EMPTY;
            acc_reg   <= '0;
            count_reg <= '0;
            dout_reg  <= '0;
            par_reg   <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            // Consumer takes the word; a completion below may refill it.
            if (state_reg == ST_FULL && DREADY) begin
                state_reg <= ST_EMPTY;
            end

            if (SYNC) begin
                // Drop the partial word; SIN is ignored this edge.
                acc_reg   <= '0;
                count_reg <= '0;
            end else if (SHIFT) begin
                if (last_bit) begin
                    acc_reg   <= '0;
                    count_reg <= '0;
                    if (state_reg == ST_EMPTY || DREADY) begin
                        dout_reg  <= word_next;
                        par_reg   <= par_chain[WIDTH-1];
                        state_reg <= ST_FULL;
                    end else begin
                        // Output still occupied and not being read: lose word.
                        ovf_reg <= 1'b1;
                    end
                end else begin
                    acc_reg   <= word_next[WIDTH-2:0];
                    count_reg <= count_reg + CW'(1);
                end
            end
        end
    end

    assign DOUT   = dout_reg;
    assign DVALID = (state_reg == ST_FULL);
    assign PAR    = par_reg;
    assign OVF    = ovf_reg;
    assign COUNT  = count_reg;

endmodule

// File: tb/tb_shift_deserializer.sv
// tb_shift_deserializer
// Directed stimulus with a scoreboard: expected words are queued as they are
// sent, and a monitor pops and compares on every output transfer.
module tb_shift_deserializer;

    logic       clk;
    logic       clr;
    logic       drv_sin;
    logic       drv_shift;
    logic       sync;
    logic       dready;
    logic [7:0] dout;
    logic       dvalid;
    logic       par;
    logic       ovf;
    logic [3:0] count;

    // Upstream parallel-load / shift-left register model.
    logic       use_up;
    logic [7:0] up_s;
    logic       up_s0;
    logic [7:0] up_t;
    logic       sin_w;
    logic       shift_w;

    int tests = 0;
    int fails = 0;

    logic [8:0] exp_q[$];   // {par, dout}

    assign sin_w   = use_up ? up_t[7] : drv_sin;
    assign shift_w = use_up ? up_s0   : drv_shift;

    shift_deserializer #(.WIDTH(8)) dut (
        .CLK    (clk),
        .Clr    (clr),
        .SIN    (sin_w),
        .SHIFT  (shift_w),
        .SYNC   (sync),
        .DREADY (dready),
        .DOUT   (dout),
        .DVALID (dvalid),
        .PAR    (par),
        .OVF    (ovf),
        .COUNT  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!up_s0) up_t <= up_s;
        else        up_t <= {up_t[6:0], 1'b0};
    end

    // Monitor: a transfer happens at the next edge when DVALID and DREADY.
    always @(negedge clk) begin
        logic [8:0] e;
        if (dvalid === 1'b1 && dready === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: got dout=%02h par=%0b, no word expected", dout, par);
            end else begin
                e = exp_q.pop_front();
                if (dout !== e[7:0] || par !== e[8]) begin
                    fails++;
                    $display("FAIL sb_word: got dout=%02h par=%0b, expected dout=%02h par=%0b",
                             dout, par, e[7:0], e[8]);
                end else begin
                    $display("[TB] transfer dout=%02h par=%0b ok", dout, par);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end else begin
            $display("[TB] %s = %0h ok", name, act);
        end
    endtask

    task automatic step(input logic s_in, input logic s_shift, input logic s_sync);
        drv_sin   = s_in;
        drv_shift = s_shift;
        sync      = s_sync;
        @(posedge clk);
        #1;
    endtask

    // Shift a full byte MSB first; DREADY takes rdy_last on the final bit.
    task automatic send_byte(input logic [7:0] b, input logic rdy_last);
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) dready = rdy_last;
            step(b[i], 1'b1, 1'b0);
        end
    endtask

    task automatic push_exp(input logic [7:0] b);
        exp_q.push_back({^b, b});
    endtask

    initial begin
        logic [7:0] gap_b;
        clr = 1'b0; drv_sin = 1'b0; drv_shift = 1'b0; sync = 1'b0; dready = 1'b0;
        use_up = 1'b0; up_s = 8'h00; up_s0 = 1'b1;

        // Reset held for 2 edges with shifting and toggling data.
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("rst_dout",   dout,   0);
        check("rst_dvalid", dvalid, 0);
        check("rst_par",    par,    0);
        check("rst_ovf",    ovf,    0);
        check("rst_count",  count,  0);
        clr = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        check("first_bit_count", count, 1);

        // Single word 0xA5, held until one DREADY cycle.
        step(1'b0, 1'b0, 1'b1);
        check("sync_count", count, 0);
        push_exp(8'hA5);
        send_byte(8'hA5, 1'b0);
        check("a5_dout",   dout,   8'hA5);
        check("a5_dvalid", dvalid, 1);
        check("a5_par",    par,    0);
        check("a5_count",  count,  0);
        dready = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        dready = 1'b0;
        check("a5_consumed_dvalid", dvalid, 0);
        check("a5_hold_dout",       dout,   8'hA5);

        // Gapped 0x3C, then 0xFF back-to-back accepted on the completing edge.
        gap_b = 8'h3C;
        push_exp(8'h3C);
        for (int i = 7; i >= 4; i--) step(gap_b[i], 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        check("gap_count", count, 4);
        check("gap_dvalid", dvalid, 0);
        for (int i = 3; i >= 0; i--) step(gap_b[i], 1'b1, 1'b0);
        check("3c_dout",   dout,   8'h3C);
        check("3c_par",    par,    0);
        check("3c_dvalid", dvalid, 1);
        push_exp(8'hFF);
        send_byte(8'hFF, 1'b1);
        check("ff_dvalid_kept", dvalid, 1);
        check("ff_dout",        dout,   8'hFF);
        check("ff_par",         par,    0);
        check("ff_ovf",         ovf,    0);
        step(1'b0, 1'b0, 1'b0);
        dready = 1'b0;
        check("ff_consumed_dvalid", dvalid, 0);

        // Odd-parity word.
        push_exp(8'h07);
        send_byte(8'h07, 1'b0);
        check("07_dout", dout, 8'h07);
        check("07_par",  par,  1);
        dready = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        dready = 1'b0;

        // Overrun: 0x81 held, 0x7E dropped.
        push_exp(8'h81);
        send_byte(8'h81, 1'b0);
        check("81_ovf_before", ovf, 0);
        send_byte(8'h7E, 1'b0);
        check("ovr_dout",   dout,   8'h81);
        check("ovr_ovf",    ovf,    1);
        check("ovr_dvalid", dvalid, 1);
        dready = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        dready = 1'b0;
        check("ovr_consumed_dvalid", dvalid, 0);
        check("ovr_sticky",          ovf,    1);

        // SYNC mid-word with SHIFT=1, then 0xC3.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        check("mid_count", count, 5);
        step(1'b1, 1'b1, 1'b1);
        check("mid_sync_count", count, 0);
        check("mid_sync_dvalid", dvalid, 0);
        push_exp(8'hC3);
        send_byte(8'hC3, 1'b0);
        check("c3_dout", dout, 8'hC3);
        check("c3_par",  par,  0);
        dready = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        dready = 1'b0;

        // End-to-end through the upstream register: load 0x96 with SYNC.
        use_up = 1'b1;
        up_s   = 8'h96;
        up_s0  = 1'b0;
        push_exp(8'h96);
        step(1'b0, 1'b0, 1'b1);
        up_s0 = 1'b1;
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0);
        check("e2e_dvalid_early", dvalid, 0);
        check("e2e_count_7",      count,  7);
        step(1'b0, 1'b0, 1'b0);
        check("e2e_dvalid", dvalid, 1);
        check("e2e_dout",   dout,   8'h96);
        check("e2e_par",    par,    0);
        check("e2e_ovf",    ovf,    1);
        up_s0 = 1'b0;
        use_up = 1'b0;
        dready = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        dready = 1'b0;

        // Mid-word reset clears everything including the sticky flag.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        clr = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        clr = 1'b1;
        check("clr_count", count, 0);
        check("clr_ovf",   ovf,   0);
        check("clr_dout",  dout,  0);
        check("clr_dvalid", dvalid, 0);

        step(1'b0, 1'b0, 1'b0);
        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shift_deserializer.md
# shift_deserializer

Downstream consumer of the 8-bit parallel-load/shift-left register. Samples the bit shifted out of the register MSB (T[7]) on every shift cycle, reassembles MSB-first bytes, and presents each completed byte with even parity on a valid/ready output handshake. Overruns are flagged stickily, and a SYNC input realigns byte framing.

## Interface

- WIDTH, 8: bits per assembled word.
- CLK  input  1  rising-edge clock, shared with the upstream register.
- Clr  input  1  synchronous, active-low reset; sampled on the CLK rising edge.
- SIN  input  1  serial data, MSB first; wired to upstream T[WIDTH-1].
- SHIFT  input  1  SIN valid this cycle; wired to upstream s0 (1 = shift).
- SYNC  input  1  discard the partial word and restart framing at bit 0.
- DREADY  input  1  consumer accepts DOUT this cycle.
- DOUT  output  WIDTH  assembled word, MSB = first bit received.
- DVALID  output  1  DOUT holds an unconsumed word.
- PAR  output  1  XOR of all DOUT bits, registered with DOUT.
- OVF  output  1  sticky overrun flag.
- COUNT  output  ceil(log2(WIDTH+1))  bits currently collected in the partial word (0..WIDTH-1).

## Operation

- Internal shift accumulator ACC[WIDTH-1:0] plus bit counter COUNT.
- Per-edge priority: Clr low > SYNC > SHIFT > hold.
- Clr low at an edge: ACC, COUNT, DOUT, DVALID, PAR and OVF all go to 0. Applies mid-word too; the partial word is lost.
- SYNC=1: ACC=0 and COUNT=0.
  - SIN is discarded even if SHIFT=1.
  - DOUT, DVALID, PAR and OVF are untouched.
  - The handshake still completes normally if DVALID&DREADY.
- SHIFT=1 and COUNT<WIDTH-1: ACC={ACC[WIDTH-2:0],SIN} and COUNT+1.
- SHIFT=1 and COUNT=WIDTH-1 (completion): the word is W={ACC[WIDTH-2:0],SIN}, and COUNT returns to 0.
  - If DVALID=0, or DVALID=1 with DREADY=1: DOUT=W, PAR=^W, DVALID=1.
  - If DVALID=1 with DREADY=0: W is dropped, OVF=1, and DOUT, PAR and DVALID are unchanged.
- SHIFT=0: ACC and COUNT hold. Gaps of any length inside a word are legal.
- Output side has two states, EMPTY (DVALID=0) and FULL (DVALID=1):
  - EMPTY -> FULL on completion.
  - FULL -> EMPTY on DREADY=1 without a simultaneous completion.
  - FULL -> FULL on DREADY=1 with a simultaneous completion (new word replaces old, no overrun).
- DREADY is ignored while DVALID=0.
- DOUT holds its value after consumption; it is not cleared.
- OVF clears only via Clr.

## Timing

- Reset values: DOUT=0, DVALID=0, PAR=0, OVF=0, COUNT=0.
- Latency: DVALID rises on the same edge that samples the WIDTH-th bit, i.e. it is visible in the cycle after the last SHIFT=1 cycle.
- Full-rate streaming (SHIFT held at 1, DREADY held at 1) yields one word every WIDTH cycles with no loss.
- Handshake: a transfer occurs at an edge where DVALID=1 and DREADY=1. DVALID falls after that edge unless a completion coincides.
- All outputs are registered; there is no combinational path from any input to any output.
- Upstream alignment: after an upstream parallel load (s0=0), the first shift cycle presents the loaded T[7] on SIN. Word n is therefore the loaded byte when SYNC is pulsed in the load cycle.

## Test plan

- Reset: hold Clr=0 for 2 edges with SHIFT=1 and SIN toggling -> all outputs 0 and COUNT=0. Release Clr -> first sampled bit gives COUNT=1.
- Single word: SYNC=1 for one cycle, then shift bits 1,0,1,0,0,1,0,1 with DREADY=0 -> after the 8th edge DOUT=0xA5, DVALID=1, PAR=0, COUNT=0. DREADY=1 for one cycle -> DVALID=0 and DOUT stays 0xA5.
- Gapped and back-to-back: send 0x3C with SHIFT=0 for 3 cycles after bit 4, then 0xFF immediately, with DREADY held at 1 -> DOUT=0x3C/PAR=0, then DOUT=0xFF/PAR=0. DVALID stays 1 across the coincident accept+completion edge, and OVF=0.
- Overrun: complete 0x81 with DREADY=0, then complete 0x7E with DREADY still 0 -> DOUT remains 0x81 and OVF=1. DREADY=1 -> DVALID=0 while OVF stays 1 until Clr.
- SYNC mid-word: shift 5 bits, pulse SYNC with SHIFT=1, then shift 0xC3 -> COUNT goes to 0 at SYNC and the next word is DOUT=0xC3, PAR=0.
- End-to-end: drive the upstream register with S=0x96, s0=0 for one cycle (with SYNC=1), then s0=1 for 8 cycles -> DOUT=0x96, PAR=0, DVALID=1 on the edge after the 8th shift.
